axis_broadcast_masked: RTL
==========================

Name: axis_broadcast_masked

Overview:
AXI4-Stream 1-to-M_COUNT broadcaster with a per-beat destination mask and independent per-output acceptance.
- Each output takes a beat exactly once, whenever its own tready is high. The beat retires when every selected output has taken it.
- Registered outputs, registered s_axis_tready, two-entry buffering (output register plus temp register). This gives full throughput.
- Sits between the command/stream front end and the parallel pipeline consumers, where not every consumer needs every beat.

Parameters:
M_COUNT, 4, number of outputs (1..32)
DATA_WIDTH, 8, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, output tkeep is all ones
KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
LAST_ENABLE, 1, propagate tlast; when 0, output tlast is 1
USER_ENABLE, 1, propagate tuser; when 0, output tuser is 0
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input keep
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready (registered)
s_axis_tlast  in  1  input last
s_axis_tuser  in  USER_WIDTH  input user
s_axis_tmask  in  M_COUNT  destination mask; bit i set means output i receives the beat
m_axis_tdata  out  M_COUNT*DATA_WIDTH  replicated data
m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  replicated keep
m_axis_tvalid  out  M_COUNT  per-output valid
m_axis_tready  in  M_COUNT  per-output ready
m_axis_tlast  out  M_COUNT  replicated last
m_axis_tuser  out  M_COUNT*USER_WIDTH  replicated user

Behaviour:
- Reset (synchronous, active-high, wins over all other updates):
  - s_axis_tready=0, m_axis_tvalid=0, temp valid=0.
  - Data registers are not reset.
  - s_axis_tready rises on the first cycle after rst deasserts.
- State:
  - out_pend[M_COUNT] drives m_axis_tvalid.
  - temp_pend[M_COUNT] and the temp data registers form the skid entry.
- Every cycle: out_pend_next = out_pend & ~m_axis_tready. An output drops valid only for itself once its handshake completes. It never re-presents the same beat.
- out_free = (out_pend_next == 0). This covers an empty register, or all remaining pending outputs accepting this cycle.
- Input accept = s_axis_tvalid & s_axis_tready.
  - Mask applied to an accepted beat is eff_mask (s_axis_tmask unless the optional feature is defined).
  - If eff_mask==0, the beat is consumed and discarded: no output valid, no storage, no stall.
- Accept with nonzero mask:
  - if out_free: load output register; out_pend = eff_mask.
  - else: load temp; temp_pend = eff_mask.
- No accept, temp nonzero and out_free: move temp to output; temp_pend = 0.
- s_axis_tready_next = out_free || (temp_pend==0 && (out_pend==0 || !s_axis_tvalid)).
  - Temp is never overwritten while nonzero.
- Timing:
  - Latency: input accept to m_axis_tvalid is 1 cycle.
  - Throughput: 1 beat/cycle while all selected outputs are ready.
- Order: beats leave in input order on every output. A later beat never appears on output i before an earlier beat selected for i.
- Payload: tdata/tkeep/tlast/tuser are identical on all outputs. Values on outputs with tvalid=0 are don't-care.
- Reset mid-operation: pending beats are lost, and no partial-beat valid survives.

Optional Feature:
AXIS_BROADCAST_MASKED_PACKET_MASK_EN
- Defined:
  - eff_mask is sampled from s_axis_tmask on the first accepted beat of each packet (first beat after reset, or the beat after an accepted tlast beat).
  - It is held in a register for all remaining beats of that packet. s_axis_tmask is ignored mid-packet.
  - A zero mask drops the whole packet.
  - Requires LAST_ENABLE=1.
- Undefined: eff_mask = s_axis_tmask on every beat; no packet tracking logic.

Decomposition:
- Package axis_broadcast_masked_pkg holds:
  - MAX_M_COUNT=32.
  - Helper function all_accepted(pend, ready), returning (pend & ~ready)==0.
- One natural sub-module, axis_mask_latch: first-beat tracking and mask hold, instantiated only under the macro.
- The datapath stays in the top module.

Test Plan:
- Reset: hold rst 3 cycles with s_axis_tvalid=1 -> s_axis_tready=0 and m_axis_tvalid=0 during reset; s_axis_tready=1 the cycle after release.
- Full broadcast: M_COUNT=4, mask=4'b1111, all ready, 8 beats 0x00..0x07 -> each output sees 0x00..0x07 in order; one beat per cycle; latency 1.
- Subset: beats 0xA1 mask 4'b0101, 0xB2 mask 4'b1010 -> outputs 0 and 2 see only 0xA1; outputs 1 and 3 see only 0xB2.
- Staggered ready: mask 4'b0011, output 0 ready, output 1 ready low for 3 cycles -> output 0 tvalid for 1 cycle only; output 1 tvalid 4 cycles; next beat held in temp; s_axis_tready low until output 1 accepts; no loss or duplication.
- Zero mask: beat 0x55 mask 0 between 0x11 and 0x22 (mask 4'b1111) -> 0x55 accepted, never appears; outputs see 0x11, 0x22 back-to-back.
- Packet mode (macro defined): 3-beat packet with mask 4'b0001 on beat 0, 4'b1110 on beats 1–2 -> all 3 beats go only to output 0; the next packet uses its own first-beat mask.

Source files
------------

// File: rtl/axis_broadcast_masked_pkg.sv
// axis_broadcast_masked_pkg
// Shared constants and helpers for the masked AXI4-Stream broadcaster.
//   MAX_M_COUNT   : widest supported output fan-out
//   all_accepted(): true when every pending output has its ready high this
//                   cycle, which means the output register is free after the edge
package axis_broadcast_masked_pkg;

  localparam int MAX_M_COUNT = 32;

  function automatic logic all_accepted(input logic [MAX_M_COUNT-1:0] pend,
                                        input logic [MAX_M_COUNT-1:0] ready);
    return (pend & ~ready) == '0;
  endfunction

endpackage

// File: rtl/axis_broadcast_masked_if.sv
// axis_broadcast_masked_if
// Bundles the broadcaster's upstream (s_axis_*) and downstream (m_axis_*)
// stream signals.
//   modport slave  : the broadcaster's view. It receives s_axis and drives m_axis.
//   modport master : the environment's view. It drives s_axis and receives m_axis.
// The m_axis vectors are flat, with output i occupying slice i.
interface axis_broadcast_masked_if
  import axis_broadcast_masked_pkg::*;
#(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]         s_axis_tdata;
  logic [KEEP_WIDTH-1:0]         s_axis_tkeep;
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic                          s_axis_tlast;
  logic [USER_WIDTH-1:0]         s_axis_tuser;
  logic [M_COUNT-1:0]            s_axis_tmask;

  logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
  logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep;
  logic [M_COUNT-1:0]            m_axis_tvalid;
  logic [M_COUNT-1:0]            m_axis_tready;
  logic [M_COUNT-1:0]            m_axis_tlast;
  logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
           s_axis_tuser, s_axis_tmask, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
           s_axis_tuser, s_axis_tmask, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/axis_broadcast_masked_mask_latch.sv
// axis_mask_latch
// Per-packet destination mask hold, used when
// AXIS_BROADCAST_MASKED_PACKET_MASK_EN is defined.
// The mask of the first accepted beat of each packet is captured and applied
// to every later beat of that packet.
//   clk, rst  : clock and synchronous active-high reset
//   accept    : an input beat is transferred this cycle
//   tlast     : last flag of the input beat
//   tmask     : raw destination mask from the input
//   eff_mask  : the mask that governs the current input beat
module axis_mask_latch
  import axis_broadcast_masked_pkg::*;
#(
  parameter int M_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               tlast,
  input  logic [M_COUNT-1:0] tmask,
  output logic [M_COUNT-1:0] eff_mask
);

  logic               first;
  logic [M_COUNT-1:0] held;

  // On the first beat, the live mask is used directly so that no cycle is lost.
  assign eff_mask = first ? tmask : held;

  always_ff @(posedge clk) begin
    if (rst) begin
      first <= 1'b1;
      held  <= '0;
    end else if (accept) begin
      if (first) held <= tmask;
      first <= tlast;
    end
  end

endmodule

// File: rtl/axis_broadcast_masked.sv
// axis_broadcast_masked
// 1-to-M_COUNT AXI4-Stream broadcaster with a per-beat destination mask.
// Each selected output takes the beat independently. A beat retires once all
// selected outputs have taken it.
// The design uses an output register plus a one-entry skid (temp) register.
// s_axis_tready is registered, and the block sustains full throughput.
//   clk, rst : clock and synchronous active-high reset
//   bus      : axis_broadcast_masked_if.slave (s_axis_* in, m_axis_* out)
// Optional macro AXIS_BROADCAST_MASKED_PACKET_MASK_EN: the mask is taken from
// the first beat of each packet and held until tlast (needs LAST_ENABLE=1).
module axis_broadcast_masked
  import axis_broadcast_masked_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input logic                    clk,
  input logic                    rst,
  axis_broadcast_masked_if.slave bus
);

  logic [M_COUNT-1:0]    out_pend, out_pend_next, temp_pend, eff_mask;
  logic                  s_ready, accept, out_free, keep_beat;
  logic                  load_out, load_temp, move_temp;

  logic [DATA_WIDTH-1:0] out_data, temp_data;
  logic [KEEP_WIDTH-1:0] out_keep, temp_keep;
  logic                  out_last, temp_last;
  logic [USER_WIDTH-1:0] out_user, temp_user;

  assign accept = bus.s_axis_tvalid & s_ready;

`ifdef AXIS_BROADCAST_MASKED_PACKET_MASK_EN
  axis_mask_latch #(.M_COUNT(M_COUNT)) u_mask_latch (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .tlast    (bus.s_axis_tlast),
    .tmask    (bus.s_axis_tmask),
    .eff_mask (eff_mask)
  );
`else
  assign eff_mask = bus.s_axis_tmask;
`endif

  always_comb begin
    out_pend_next = out_pend & ~bus.m_axis_tready;
    // The register is free if it is empty, or if every pending output takes its beat now.
    out_free  = all_accepted(MAX_M_COUNT'(out_pend), MAX_M_COUNT'(bus.m_axis_tready));
    // A zero-mask beat is still handshaken but has no destination, so it is dropped.
    keep_beat = accept && (eff_mask != '0);
    load_out  = keep_beat && out_free;
    load_temp = keep_beat && !out_free;
    move_temp = !keep_beat && (temp_pend != '0) && out_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b0;
      out_pend  <= '0;
      temp_pend <= '0;
    end else begin
      // Readiness is predicted one cycle ahead. The skid entry is never
      // overwritten, because ready drops whenever a beat may have to park there.
      s_ready  <= out_free || ((temp_pend == '0) &&
                  ((out_pend == '0) || !bus.s_axis_tvalid));
      out_pend <= out_pend_next;
      if (load_out) begin
        out_pend <= eff_mask;
      end else if (load_temp) begin
        temp_pend <= eff_mask;
      end else if (move_temp) begin
        out_pend  <= temp_pend;
        temp_pend <= '0;
      end
    end
  end

  // The payload registers have no reset. Their validity is carried only by the pend masks.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_data <= bus.s_axis_tdata;
      out_keep <= bus.s_axis_tkeep;
      out_last <= bus.s_axis_tlast;
      out_user <= bus.s_axis_tuser;
    end else if (move_temp) begin
      out_data <= temp_data;
      out_keep <= temp_keep;
      out_last <= temp_last;
      out_user <= temp_user;
    end
    if (load_temp) begin
      temp_data <= bus.s_axis_tdata;
      temp_keep <= bus.s_axis_tkeep;
      temp_last <= bus.s_axis_tlast;
      temp_user <= bus.s_axis_tuser;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = out_pend;
  assign bus.m_axis_tdata  = {M_COUNT{out_data}};
  assign bus.m_axis_tkeep  = {M_COUNT{(KEEP_ENABLE != 0) ? out_keep : {KEEP_WIDTH{1'b1}}}};
  assign bus.m_axis_tlast  = {M_COUNT{(LAST_ENABLE != 0) ? out_last : 1'b1}};
  assign bus.m_axis_tuser  = {M_COUNT{(USER_ENABLE != 0) ? out_user : {USER_WIDTH{1'b0}}}};

endmodule
